// File: rtl/mem_pkg.sv
// Shared encodings for the load/store path: size codes, RW codes,
// fault codes and the sequencer state type.
package mem_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam logic [1:0] FLT_NONE    = 2'b00;
  localparam logic [1:0] FLT_ALIGN   = 2'b01;
  localparam logic [1:0] FLT_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_RESP  = 2'b11
  } state_t;

  // True for any request that must not reach the RAM: odd halfword,
  // non-word-aligned word, or the reserved size code.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] adr_lo);
    logic bad;
    bad = 1'b0;
    case (size)
      SIZE_B:  bad = 1'b0;
      SIZE_H:  bad = adr_lo[0];
      SIZE_W:  bad = (adr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_load_extend.sv
// Sign/zero extension of raw RAM read data according to access size.
// Kept standalone so the writeback mux can share it.
module load_extend
  import mem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        size,
  input  logic              sgn,
  input  logic [DATA_W-1:0] raw,
  output logic [DATA_W-1:0] ext
);

  // Pick the live bits and fill the rest with zero or the sign bit
  always_comb begin
    ext = raw;
    case (size)
      SIZE_B:  ext = {{(DATA_W-8){sgn & raw[7]}}, raw[7:0]};
      SIZE_H:  ext = {{(DATA_W-16){sgn & raw[15]}}, raw[15:0]};
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer in front of the byte-addressed RAM. One request
// at a time: alignment check, RAM handshake with timeout, extended load
// data and a one-cycle done pulse with a fault code.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W         = 9,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_load,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              ram_en,
  output logic              ram_rw,
  output logic [ADDR_W-1:0] ram_adr,
  output logic [DATA_W-1:0] ram_data,
  output logic [1:0]        ram_size,
  input  logic [DATA_W-1:0] ram_out,
  input  logic              ram_finished,
  output logic [DATA_W-1:0] rdata,
  output logic              done,
  output logic [1:0]        fault
);

  // Counter value at which the wait is abandoned; the check looks at the
  // incremented value so ram_en stays high for exactly TIMEOUT_CYCLES.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t            state;
  logic [7:0]        cnt;
  logic              sgn_q;
  logic [DATA_W-1:0] ext_data;

  load_extend #(.DATA_W(DATA_W)) u_ext (
    .size (ram_size),
    .sgn  (sgn_q),
    .raw  (ram_out),
    .ext  (ext_data)
  );

  assign req_ready = (state == ST_IDLE);

  // Request sequencing: accept, drive the RAM, wait for finished or timeout, respond
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      sgn_q    <= 1'b0;
      ram_en   <= 1'b0;
      ram_rw   <= 1'b0;
      ram_adr  <= '0;
      ram_data <= '0;
      ram_size <= '0;
      rdata    <= '0;
      done     <= 1'b0;
      fault    <= FLT_NONE;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            if (is_misaligned(req_size, req_addr[1:0])) begin
              state <= ST_RESP;
              done  <= 1'b1;
              fault <= FLT_ALIGN;
              rdata <= '0;
            end else begin
              state    <= ST_ISSUE;
              ram_en   <= 1'b1;
              ram_rw   <= req_load ? RW_READ : RW_WRITE;
              ram_adr  <= req_addr;
              ram_data <= req_wdata;
              ram_size <= req_size;
              sgn_q    <= req_signed;
            end
          end
        end
        ST_ISSUE: begin
          cnt   <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          // finished is tested first so it wins a tie with the timeout
          if (ram_finished) begin
            ram_en <= 1'b0;
            state  <= ST_RESP;
            done   <= 1'b1;
            fault  <= FLT_NONE;
            rdata  <= (ram_rw == RW_READ) ? ext_data : '0;
          end else if ((cnt + 8'd1) == TO_LAST) begin
            ram_en <= 1'b0;
            state  <= ST_RESP;
            done   <= 1'b1;
            fault  <= FLT_TIMEOUT;
            rdata  <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state  <= ST_IDLE;
          ram_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural byte RAM and a
// scoreboard of expected responses.
module tb_mem_access_ctrl;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;
  localparam int TO     = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_load = 1'b0;
  logic [1:0]        req_size = 2'b00;
  logic              req_signed = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              ram_en;
  logic              ram_rw;
  logic [ADDR_W-1:0] ram_adr;
  logic [DATA_W-1:0] ram_data;
  logic [1:0]        ram_size;
  logic [DATA_W-1:0] ram_out = '0;
  logic              ram_finished = 1'b0;
  logic [DATA_W-1:0] rdata;
  logic              done;
  logic [1:0]        fault;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_load(req_load),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .ram_en(ram_en), .ram_rw(ram_rw), .ram_adr(ram_adr), .ram_data(ram_data),
    .ram_size(ram_size), .ram_out(ram_out), .ram_finished(ram_finished),
    .rdata(rdata), .done(done), .fault(fault)
  );

  // Behavioural RAM: finishes ram_lat edges after ram_en rises (never if < 0).
  // Upper read bits carry junk so extension must ignore them.
  logic [7:0] mem [512];
  int ram_lat = 1;
  int rcnt = 0;

  always @(posedge clk) begin
    int a;
    a = int'(ram_adr);
    if (!ram_en) begin
      rcnt = 0;
      ram_finished <= 1'b0;
    end else begin
      rcnt = rcnt + 1;
      if (!ram_finished && ram_lat >= 0 && rcnt >= ram_lat) begin
        ram_finished <= 1'b1;
        if (ram_rw) begin
          case (ram_size)
            2'b00:   ram_out <= {24'hDEADBE, mem[a]};
            2'b01:   ram_out <= {16'hDEAD, mem[(a+1)%512], mem[a]};
            default: ram_out <= {mem[(a+3)%512], mem[(a+2)%512], mem[(a+1)%512], mem[a]};
          endcase
        end else begin
          mem[a] = ram_data[7:0];
          if (ram_size != 2'b00) mem[(a+1)%512] = ram_data[15:8];
          if (ram_size == 2'b10) begin
            mem[(a+2)%512] = ram_data[23:16];
            mem[(a+3)%512] = ram_data[31:24];
          end
        end
      end
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  fault;
    int          lat;
    int          en;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues one request (called at a negedge, returns at a negedge) and checks
  // the response against the scoreboard entry pushed here.
  task automatic do_req(input bit load, input logic [1:0] size, input bit sgn,
                        input int addr, input logic [31:0] wd, input int lat,
                        input logic [31:0] exp_rd, input bit hold_valid);
    exp_t e, got;
    bit   mis, tmo;
    int   n, en_cnt, rw_bad, w;
    mis = (size == 2'b11) || (size == 2'b01 && addr[0]) ||
          (size == 2'b10 && addr[1:0] != 2'b00);
    tmo = !mis && (lat < 0 || lat > TO - 1);
    e.rdata = (mis || tmo || !load) ? 32'h0 : exp_rd;
    e.fault = mis ? 2'b01 : (tmo ? 2'b10 : 2'b00);
    e.lat   = mis ? 1 : (tmo ? TO + 1 : lat + 2);
    e.en    = mis ? 0 : (tmo ? TO : lat + 1);
    sb.push_back(e);
    ram_lat    = lat;
    req_load   = load;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr[ADDR_W-1:0];
    req_wdata  = wd;
    req_valid  = 1'b1;
    w = 0;
    while (!req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("ready_before_accept", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    if (!hold_valid) req_valid = 1'b0;
    n = 0; en_cnt = 0; rw_bad = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (ram_en) begin
        en_cnt++;
        if (ram_rw !== load) rw_bad++;
      end
      if (done) break;
    end
    check("done_seen", {31'b0, done}, 32'd1);
    got = sb.pop_front();
    check("rdata", rdata, got.rdata);
    check("fault", {30'b0, fault}, {30'b0, got.fault});
    check("done_latency", n, got.lat);
    check("ram_en_cycles", en_cnt, got.en);
    check("ram_rw", rw_bad, 32'd0);
    check("ready_in_resp", {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    check("done_one_cycle", {31'b0, done}, 32'd0);
    check("ram_en_gap", {31'b0, ram_en}, 32'd0);
    check("ready_after_resp", {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    int dcnt;
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_ram_en", {31'b0, ram_en}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_fault", {30'b0, fault}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_ram_adr", {23'b0, ram_adr}, 32'd0);
    check("rst_ram_data", ram_data, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // byte store and signed/unsigned reloads
    do_req(1'b0, 2'b00, 1'b0, 3, 32'h000000A5, 1, 32'h0, 1'b0);
    do_req(1'b1, 2'b00, 1'b1, 3, 32'h0, 1, 32'hFFFFFFA5, 1'b0);
    do_req(1'b1, 2'b00, 1'b0, 3, 32'h0, 2, 32'h000000A5, 1'b0);
    // halfword
    do_req(1'b0, 2'b01, 1'b0, 2, 32'h00008001, 1, 32'h0, 1'b0);
    do_req(1'b1, 2'b01, 1'b1, 2, 32'h0, 3, 32'hFFFF8001, 1'b0);
    do_req(1'b1, 2'b01, 1'b0, 2, 32'h0, 1, 32'h00008001, 1'b0);
    // word (sign flag ignored)
    do_req(1'b0, 2'b10, 1'b0, 0, 32'h12345678, 1, 32'h0, 1'b0);
    do_req(1'b1, 2'b10, 1'b1, 0, 32'h0, 1, 32'h12345678, 1'b0);
    // alignment faults
    do_req(1'b1, 2'b01, 1'b0, 1, 32'h0, 1, 32'h0, 1'b0);
    do_req(1'b1, 2'b10, 1'b0, 2, 32'h0, 1, 32'h0, 1'b0);
    do_req(1'b0, 2'b11, 1'b0, 0, 32'hFFFFFFFF, 1, 32'h0, 1'b0);
    // timeout, finished on the timeout edge, finished one edge too late
    do_req(1'b1, 2'b10, 1'b0, 0, 32'h0, -1, 32'h0, 1'b0);
    do_req(1'b1, 2'b10, 1'b0, 0, 32'h0, 15, 32'h12345678, 1'b0);
    do_req(1'b1, 2'b10, 1'b0, 4, 32'h0, 16, 32'h0, 1'b0);
    // back-to-back with valid held high
    do_req(1'b1, 2'b00, 1'b0, 0, 32'h0, 1, 32'h00000078, 1'b1);
    do_req(1'b1, 2'b00, 1'b1, 1, 32'h0, 1, 32'h00000056, 1'b0);

    // reset in the middle of a wait
    ram_lat    = -1;
    req_load   = 1'b0;
    req_size   = 2'b10;
    req_addr   = 9'd8;
    req_wdata  = 32'hCAFEF00D;
    req_valid  = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_ram_en_high", {31'b0, ram_en}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ram_en", {31'b0, ram_en}, 32'd0);
    check("mid_rst_ready", {31'b0, req_ready}, 32'd1);
    check("mid_rst_done", {31'b0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("no_done_after_rst", dcnt, 32'd0);
    check("ready_after_rst", {31'b0, req_ready}, 32'd1);
    check("store_discarded", {mem[11], mem[10], mem[9], mem[8]}, 32'h0);

    // normal operation resumes
    do_req(1'b1, 2'b01, 1'b1, 0, 32'h0, 1, 32'h00005678, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
